// File: rtl/sb_pkg.sv
// Store buffer shared types: entry layout, drain FSM encoding, default depth.
package sb_pkg;

   localparam int SB_DEPTH_DEF = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] data;
   } sb_entry_t;

   typedef enum logic [0:0] {
      SB_IDLE = 1'b0,
      SB_REQ  = 1'b1
   } sb_state_e;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding: word-address compare against every buffered
// entry, youngest match selected. Only instantiated when SB_FWD_EN is defined.
module sb_fwd_match
   import sb_pkg::*;
#(
   parameter int SB_DEPTH = SB_DEPTH_DEF
)(
   input  sb_entry_t [SB_DEPTH-1:0]         entries,
   input  logic [$clog2(SB_DEPTH)-1:0]      rd_idx,
   input  logic                             ld_valid,
   input  logic [31:0]                      ld_addr,
   output logic                             fwd_hit,
   output logic [31:0]                      fwd_data
);

   localparam int IW = $clog2(SB_DEPTH);

   logic [SB_DEPTH-1:0] match;
   logic [SB_DEPTH-1:0] unused_addr_lo;
   logic                unused_ld_lo;
   logic [IW-1:0]       idx;

   for (genvar i = 0; i < SB_DEPTH; i++) begin : g_cmp
      assign match[i] = ld_valid && entries[i].valid &&
                        (entries[i].addr[31:2] == ld_addr[31:2]);
      assign unused_addr_lo[i] = ^entries[i].addr[1:0];
   end

   // byte offset within the word does not take part in the match
   assign unused_ld_lo = ^ld_addr[1:0];

   // walk oldest to youngest from the head; the last hit seen is the youngest
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         idx = rd_idx + k[IW-1:0];
         if (match[idx]) begin
            fwd_hit  = 1'b1;
            fwd_data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Committed-store buffer: circular FIFO of retired stores drained in order
// to the data cache by a two-state request/ack FSM. Define SB_FWD_EN to
// build store-to-load forwarding; otherwise the forwarding outputs are 0.
module store_buffer
   import sb_pkg::*;
#(
   parameter int SB_DEPTH = SB_DEPTH_DEF
)(
   input  logic        clk,
   input  logic        rst_b,
   input  logic        rob_commitmemwrite,
   input  logic [31:0] rob_swaddr,
   input  logic [31:0] rob_swdata,
   output logic        sb_full,
   output logic        sb_empty,
   output logic        sb_dcache_wr_en,
   output logic [31:0] sb_dcache_addr,
   output logic [31:0] sb_dcache_data,
   input  logic        dcache_wr_ack,
   input  logic        lsq_ld_valid,
   input  logic [31:0] lsq_ld_addr,
   output logic        sb_fwd_hit,
   output logic [31:0] sb_fwd_data
);

   localparam int IW = $clog2(SB_DEPTH);
   localparam logic [IW:0] PTR_ONE = {{IW{1'b0}}, 1'b1};

   sb_entry_t [SB_DEPTH-1:0] sb_q;
   logic [SB_DEPTH-1:0]      valid_vec;
   logic [IW:0]              wr_ptr, rd_ptr, rd_ptr_inc;
   logic [IW-1:0]            wr_idx, rd_idx;
   sb_state_e                state, state_nxt;
   logic                     fifo_empty, push, pop, remain;

   assign wr_idx     = wr_ptr[IW-1:0];
   assign rd_idx     = rd_ptr[IW-1:0];
   assign rd_ptr_inc = rd_ptr + PTR_ONE;

   // full/empty come only from the registered pointers
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign sb_full    = (wr_idx == rd_idx) && (wr_ptr[IW] != rd_ptr[IW]);

   // an ack only counts while a request is actually outstanding
   assign pop  = (state == SB_REQ) && dcache_wr_ack;
   // a slot freed by this edge's pop can take this edge's push, so
   // push+ack while full keeps occupancy unchanged
   assign push = rob_commitmemwrite && (!sb_full || pop);

   // something is still queued after this edge's pop
   assign remain = (wr_ptr != rd_ptr_inc) || push;

   for (genvar i = 0; i < SB_DEPTH; i++) begin : g_vld
      assign valid_vec[i] = sb_q[i].valid;
   end

   assign sb_empty = (state == SB_IDLE) && !(|valid_vec);

   // pointer update; both wrap modulo 2*SB_DEPTH through the extra MSB
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr_inc;
      end
   end

   // entry storage; on push+pop into the same slot the push write lands last
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         sb_q <= '0;
      end else begin
         if (pop)  sb_q[rd_idx].valid <= 1'b0;
         if (push) sb_q[wr_idx] <= '{valid: 1'b1, addr: rob_swaddr, data: rob_swdata};
      end
   end

   // drain FSM next state: request as soon as anything is (or is being) queued
   always_comb begin
      state_nxt = state;
      if (state == SB_IDLE) begin
         if (!fifo_empty || push) state_nxt = SB_REQ;
      end else begin
         if (pop && !remain) state_nxt = SB_IDLE;
      end
   end

   // drain FSM state register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= SB_IDLE;
      else        state <= state_nxt;
   end

   assign sb_dcache_wr_en = (state == SB_REQ);
   assign sb_dcache_addr  = sb_dcache_wr_en ? sb_q[rd_idx].addr : '0;
   assign sb_dcache_data  = sb_dcache_wr_en ? sb_q[rd_idx].data : '0;

`ifdef SB_FWD_EN
   sb_fwd_match #(.SB_DEPTH(SB_DEPTH)) u_fwd (
      .entries  (sb_q),
      .rd_idx   (rd_idx),
      .ld_valid (lsq_ld_valid),
      .ld_addr  (lsq_ld_addr),
      .fwd_hit  (sb_fwd_hit),
      .fwd_data (sb_fwd_data)
   );
`else
   logic unused_lsq;
   assign unused_lsq  = ^{lsq_ld_valid, lsq_ld_addr};
   assign sb_fwd_hit  = 1'b0;
   assign sb_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (SB_DEPTH = 4).
module tb_store_buffer;

`ifdef SB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk;
   logic        rst_b;
   logic        rob_commitmemwrite;
   logic [31:0] rob_swaddr, rob_swdata;
   logic        sb_full, sb_empty, sb_dcache_wr_en;
   logic [31:0] sb_dcache_addr, sb_dcache_data;
   logic        dcache_wr_ack;
   logic        lsq_ld_valid;
   logic [31:0] lsq_ld_addr;
   logic        sb_fwd_hit;
   logic [31:0] sb_fwd_data;

   int checks = 0;
   int errors = 0;

   store_buffer #(.SB_DEPTH(4)) dut (
      .clk                (clk),
      .rst_b              (rst_b),
      .rob_commitmemwrite (rob_commitmemwrite),
      .rob_swaddr         (rob_swaddr),
      .rob_swdata         (rob_swdata),
      .sb_full            (sb_full),
      .sb_empty           (sb_empty),
      .sb_dcache_wr_en    (sb_dcache_wr_en),
      .sb_dcache_addr     (sb_dcache_addr),
      .sb_dcache_data     (sb_dcache_data),
      .dcache_wr_ack      (dcache_wr_ack),
      .lsq_ld_valid       (lsq_ld_valid),
      .lsq_ld_addr        (lsq_ld_addr),
      .sb_fwd_hit         (sb_fwd_hit),
      .sb_fwd_data        (sb_fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_b = 1'b0;
      rob_commitmemwrite = 1'b0; rob_swaddr = '0; rob_swdata = '0;
      dcache_wr_ack = 1'b0; lsq_ld_valid = 1'b0; lsq_ld_addr = '0;
      #12;
      checks++;
      if ({sb_full, sb_empty, sb_dcache_wr_en, sb_fwd_hit} !== 4'b0100) begin
         errors++; $display("FAIL reset_flags got %b want 0100", {sb_full, sb_empty, sb_dcache_wr_en, sb_fwd_hit});
      end
      checks++;
      if ({sb_dcache_addr, sb_dcache_data, sb_fwd_data} !== 96'd0) begin
         errors++; $display("FAIL reset_buses got %h %h %h want 0", sb_dcache_addr, sb_dcache_data, sb_fwd_data);
      end
      @(negedge clk);
      rst_b = 1'b1;
      tick();
   endtask

   // single push with ack tied high
   task automatic test_single;
      dcache_wr_ack = 1'b1;
      rob_commitmemwrite = 1'b1; rob_swaddr = 32'h100; rob_swdata = 32'hAAAA_0001;
      tick();
      rob_commitmemwrite = 1'b0;
      checks++;
      if ({sb_dcache_wr_en, sb_dcache_addr, sb_dcache_data} !== {1'b1, 32'h100, 32'hAAAA_0001}) begin
         errors++; $display("FAIL single_req got %b %h %h want 1 00000100 aaaa0001", sb_dcache_wr_en, sb_dcache_addr, sb_dcache_data);
      end
      checks++;
      if (sb_empty !== 1'b0) begin
         errors++; $display("FAIL single_busy_empty got %b want 0", sb_empty);
      end
      tick();
      checks++;
      if ({sb_empty, sb_dcache_wr_en} !== 2'b10) begin
         errors++; $display("FAIL single_drained got empty=%b wr_en=%b want 1 0", sb_empty, sb_dcache_wr_en);
      end
      dcache_wr_ack = 1'b0;
   endtask

   // fill, drop on full, hold stable, push+ack while full, drain
   task automatic test_full;
      logic [31:0] exp_a [3];
      exp_a[0] = 32'h308; exp_a[1] = 32'h30C; exp_a[2] = 32'h340;
      dcache_wr_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sb_full !== 1'b0) begin
            errors++; $display("FAIL fill_not_full[%0d] got %b want 0", i, sb_full);
         end
         rob_commitmemwrite = 1'b1; rob_swaddr = 32'h300 + 32'(4*i); rob_swdata = 32'hC000_0000 + 32'(i);
         tick();
      end
      rob_commitmemwrite = 1'b0;
      checks++;
      if (sb_full !== 1'b1) begin
         errors++; $display("FAIL full_after_4 got %b want 1", sb_full);
      end
      rob_commitmemwrite = 1'b1; rob_swaddr = 32'h3F0; rob_swdata = 32'hDEAD_BEEF;
      tick();
      rob_commitmemwrite = 1'b0;
      checks++;
      if ({sb_full, sb_dcache_addr} !== {1'b1, 32'h300}) begin
         errors++; $display("FAIL drop_push got full=%b addr=%h want 1 00000300", sb_full, sb_dcache_addr);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({sb_dcache_wr_en, sb_dcache_addr, sb_dcache_data} !== {1'b1, 32'h300, 32'hC000_0000}) begin
            errors++; $display("FAIL hold_stable[%0d] got %b %h %h want 1 00000300 c0000000", c, sb_dcache_wr_en, sb_dcache_addr, sb_dcache_data);
         end
      end
      rob_commitmemwrite = 1'b1; rob_swaddr = 32'h340; rob_swdata = 32'hC000_0040;
      dcache_wr_ack = 1'b1;
      tick();
      rob_commitmemwrite = 1'b0; dcache_wr_ack = 1'b0;
      checks++;
      if ({sb_full, sb_dcache_addr} !== {1'b1, 32'h304}) begin
         errors++; $display("FAIL push_pop_full got full=%b addr=%h want 1 00000304", sb_full, sb_dcache_addr);
      end
      dcache_wr_ack = 1'b1;
      tick();
      dcache_wr_ack = 1'b0;
      checks++;
      if ({sb_full, sb_dcache_addr} !== {1'b0, 32'h308}) begin
         errors++; $display("FAIL ack_unfull got full=%b addr=%h want 0 00000308", sb_full, sb_dcache_addr);
      end
      dcache_wr_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({sb_dcache_wr_en, sb_dcache_addr} !== {1'b1, exp_a[k]}) begin
            errors++; $display("FAIL drain_order[%0d] got %b %h want 1 %h", k, sb_dcache_wr_en, sb_dcache_addr, exp_a[k]);
         end
         tick();
      end
      dcache_wr_ack = 1'b0;
      checks++;
      if ({sb_empty, sb_dcache_wr_en} !== 2'b10) begin
         errors++; $display("FAIL full_drained got empty=%b wr_en=%b want 1 0", sb_empty, sb_dcache_wr_en);
      end
   endtask

   task automatic test_fwd;
      logic        lv [5];
      logic [31:0] la [5];
      logic [31:0] ld [5];
      lv[0] = 1'b1; la[0] = 32'h200; ld[0] = 32'h22;
      lv[1] = 1'b1; la[1] = 32'h203; ld[1] = 32'h22;
      lv[2] = 1'b1; la[2] = 32'h204; ld[2] = 32'h0;
      lv[3] = 1'b1; la[3] = 32'h210; ld[3] = 32'h44;
      lv[4] = 1'b0; la[4] = 32'h200; ld[4] = 32'h0;
      dcache_wr_ack = 1'b0;
      rob_commitmemwrite = 1'b1; rob_swaddr = 32'h210; rob_swdata = 32'h44; tick();
      rob_swaddr = 32'h200; rob_swdata = 32'h11; tick();
      rob_swaddr = 32'h200; rob_swdata = 32'h22; tick();
      rob_commitmemwrite = 1'b0;
      for (int i = 0; i < 5; i++) begin
         lsq_ld_valid = lv[i]; lsq_ld_addr = la[i];
         #1;
         checks++;
         if ({sb_fwd_hit, sb_fwd_data} !== {FWD && (ld[i] != 0), FWD ? ld[i] : 32'h0}) begin
            errors++; $display("FAIL fwd_lookup[%0d] got hit=%b data=%h want %b %h", i, sb_fwd_hit, sb_fwd_data, FWD && (ld[i] != 0), FWD ? ld[i] : 32'h0);
         end
      end
      rob_commitmemwrite = 1'b1; rob_swaddr = 32'h220; rob_swdata = 32'h55;
      lsq_ld_valid = 1'b1; lsq_ld_addr = 32'h220;
      #1;
      checks++;
      if ({sb_fwd_hit, sb_fwd_data} !== 33'd0) begin
         errors++; $display("FAIL fwd_same_cycle got hit=%b data=%h want 0 0", sb_fwd_hit, sb_fwd_data);
      end
      tick();
      rob_commitmemwrite = 1'b0;
      checks++;
      if ({sb_fwd_hit, sb_fwd_data} !== {FWD, FWD ? 32'h55 : 32'h0}) begin
         errors++; $display("FAIL fwd_next_cycle got hit=%b data=%h want %b %h", sb_fwd_hit, sb_fwd_data, FWD, FWD ? 32'h55 : 32'h0);
      end
      lsq_ld_valid = 1'b0;
      dcache_wr_ack = 1'b1;
      for (int c = 0; c < 20 && !sb_empty; c++) tick();
      dcache_wr_ack = 1'b0;
      checks++;
      if (sb_empty !== 1'b1) begin
         errors++; $display("FAIL fwd_drain_timeout empty=%b want 1", sb_empty);
      end
   endtask

   // ten stores through the buffer with random ack gaps; pointers wrap
   task automatic test_back_to_back;
      int pushed = 0;
      int popped = 0;
      int cyc = 0;
      logic [31:0] ea, ed;
      while (popped < 10 && cyc < 500) begin
         rob_commitmemwrite = (pushed < 10) && !sb_full && ($urandom_range(0, 3) != 0);
         rob_swaddr = 32'h1000 + 32'(4*pushed);
         rob_swdata = 32'hD000_0000 + 32'(pushed);
         dcache_wr_ack = ($urandom_range(0, 2) == 0);
         #1;
         if (sb_dcache_wr_en && dcache_wr_ack) begin
            ea = 32'h1000 + 32'(4*popped);
            ed = 32'hD000_0000 + 32'(popped);
            checks++;
            if ({sb_dcache_addr, sb_dcache_data} !== {ea, ed}) begin
               errors++; $display("FAIL stream_order[%0d] got %h %h want %h %h", popped, sb_dcache_addr, sb_dcache_data, ea, ed);
            end
            popped++;
         end
         if (rob_commitmemwrite) pushed++;
         tick();
         cyc++;
      end
      rob_commitmemwrite = 1'b0; dcache_wr_ack = 1'b0;
      #1;
      checks++;
      if ({popped, sb_empty, sb_full} !== {32'd10, 1'b1, 1'b0}) begin
         errors++; $display("FAIL stream_done got popped=%0d empty=%b full=%b want 10 1 0", popped, sb_empty, sb_full);
      end
   endtask

   task automatic test_reset_mid;
      dcache_wr_ack = 1'b0;
      rob_commitmemwrite = 1'b1; rob_swaddr = 32'h500; rob_swdata = 32'h5555;
      tick();
      rob_commitmemwrite = 1'b0;
      checks++;
      if (sb_dcache_wr_en !== 1'b1) begin
         errors++; $display("FAIL rst_mid_pre wr_en=%b want 1", sb_dcache_wr_en);
      end
      #2;
      rst_b = 1'b0;
      #1;
      checks++;
      if ({sb_dcache_wr_en, sb_empty, sb_full, sb_dcache_addr} !== {3'b010, 32'h0}) begin
         errors++; $display("FAIL rst_mid_async got wr_en=%b empty=%b full=%b addr=%h want 0 1 0 0", sb_dcache_wr_en, sb_empty, sb_full, sb_dcache_addr);
      end
      @(negedge clk);
      rst_b = 1'b1;
      dcache_wr_ack = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({sb_dcache_wr_en, sb_empty, sb_full} !== 3'b010) begin
            errors++; $display("FAIL rst_mid_ack_ignored[%0d] got wr_en=%b empty=%b full=%b want 0 1 0", c, sb_dcache_wr_en, sb_empty, sb_full);
         end
      end
      dcache_wr_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_fwd();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
